// File: rtl/tmds_encoder_dvi.sv
// tmds_encoder_dvi: one DVI 1.0 TMDS channel encoder (8b/10b with DC balance).
// Stage 1 performs transition minimisation, stage 2 performs DC balancing and
// control-symbol insertion. Output latency is 2 clk_pix cycles.
// Optional build macro TMDS_ENC_REG_OUT_EN adds a retiming register on tmds
// (latency 3); symbol values are identical in both builds.
module tmds_encoder_dvi #(
    parameter logic [1:0] RST_CTRL = 2'b00
) (
    input  logic       clk_pix,
    input  logic       rstn_i,
    input  logic       de,
    input  logic [1:0] ctrl,
    input  logic [7:0] din,
    output logic [9:0] tmds
);

    // Blanking symbol for each {c1,c0} control pair.
    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            default: s = 10'h2AB;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    localparam logic [9:0] RST_SYM = ctrl_symbol(RST_CTRL);

    // Stage 1 signals
    logic [3:0] n1_din;
    logic       use_xnor;
    logic [8:0] qm_d;
    logic [8:0] qm_q;
    logic       de_q;
    logic [1:0] ctrl_q;

    // Stage 2 signals
    logic [3:0]        n1q;
    logic signed [4:0] diff;     // n1q - n0q, always even in -8..+8
    logic              case_a;
    logic              case_b;
    logic [9:0]        sym_d;
    logic [9:0]        sym_q;
    logic signed [4:0] cnt_d;
    logic signed [4:0] cnt_q;

    // Transition minimisation: chain XOR or XNOR through the data bits.
    // NOTE: every variable written in always_comb is given a value on every path first, so no latch is inferred.
    always_comb begin
        n1_din   = popcount8(din);
        use_xnor = (n1_din > 4'd4) || ((n1_din == 4'd4) && !din[0]);
        qm_d     = '0;
        qm_d[0]  = din[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ din[i]) : (qm_d[i-1] ^ din[i]);
        end
        qm_d[8] = ~use_xnor;
    end

    // Stage 1 register: q_m plus the de/ctrl that travel alongside it.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: all pipeline registers reset asynchronously to the RST_CTRL blanking state, so the first symbols after release are clean control codes.
    always_ff @(posedge clk_pix or negedge rstn_i) begin
        if (!rstn_i) begin
            qm_q   <= '0;
            de_q   <= 1'b0;
            ctrl_q <= RST_CTRL;
        end else begin
            qm_q   <= qm_d;
            de_q   <= de;
            ctrl_q <= ctrl;
        end
    end

    // DC balancing: pick inversion from running disparity, or emit a control symbol.
    always_comb begin
        n1q    = popcount8(qm_q[7:0]);
        diff   = $signed({n1q, 1'b0}) - 5'sd8;
        case_a = (cnt_q == 5'sd0) || (n1q == 4'd4);
        case_b = ((cnt_q > 5'sd0) && (n1q > 4'd4)) ||
                 ((cnt_q < 5'sd0) && (n1q < 4'd4));
        sym_d  = ctrl_symbol(ctrl_q);
        cnt_d  = 5'sd0;
        if (de_q) begin
            if (case_a) begin
                sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
            end else if (case_b) begin
                sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                cnt_d = cnt_q - diff + (qm_q[8] ? 5'sd2 : 5'sd0);
            end else begin
                sym_d = {1'b0, qm_q[8], qm_q[7:0]};
                cnt_d = cnt_q + diff - (qm_q[8] ? 5'sd0 : 5'sd2);
            end
        end
    end

    // Stage 2 register: encoded symbol and running disparity.
    always_ff @(posedge clk_pix or negedge rstn_i) begin
        if (!rstn_i) begin
            sym_q <= RST_SYM;
            cnt_q <= 5'sd0;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef TMDS_ENC_REG_OUT_EN
    logic [9:0] out_q;

    // Optional retiming register in front of the serialiser.
    always_ff @(posedge clk_pix or negedge rstn_i) begin
        if (!rstn_i) begin
            out_q <= RST_SYM;
        end else begin
            out_q <= sym_q;
        end
    end

    assign tmds = out_q;
`else
    assign tmds = sym_q;
`endif

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Self-checking bench for tmds_encoder_dvi: directed vectors with hand-computed
// symbols, asynchronous reset checks, and a random run against a behavioural model.
module tb_tmds_encoder_dvi;

    logic       clk_pix = 1'b0;
    logic       rstn_i;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] din;
    logic [9:0] tmds;

`ifdef TMDS_ENC_REG_OUT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] din;
        logic [9:0] exp;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_cnt    = 0;
    vec_t       seq[$];
    logic [9:0] exp_q[$];

    tmds_encoder_dvi #(.RST_CTRL(2'b00)) dut (
        .clk_pix (clk_pix),
        .rstn_i  (rstn_i),
        .de      (de),
        .ctrl    (ctrl),
        .din     (din),
        .tmds    (tmds)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic add(input logic d, input logic [1:0] c, input logic [7:0] x, input logic [9:0] e);
        vec_t v;
        v.de   = d;
        v.ctrl = c;
        v.din  = x;
        v.exp  = e;
        seq.push_back(v);
    endtask

    // Drive the queued vectors one per cycle; symbol k is due LAT cycles after it is driven.
    task automatic run_seq(input string tag);
        int n;
        n = seq.size();
        for (int j = 0; j < n + LAT; j++) begin
            @(negedge clk_pix);
            if (j >= LAT) check($sformatf("%s[%0d]", tag, j - LAT), tmds, seq[j - LAT].exp);
            if (j < n) begin
                de   = seq[j].de;
                ctrl = seq[j].ctrl;
                din  = seq[j].din;
            end else begin
                de   = 1'b0;
                ctrl = 2'b00;
                din  = 8'h00;
            end
        end
        seq.delete();
    endtask

    // Behavioural encoder written from the DVI balancing rules with plain integers.
    task automatic model_step(input logic d, input logic [1:0] c, input logic [7:0] x,
                              output logic [9:0] s);
        int         n1;
        int         n1q;
        int         n0q;
        bit         xn;
        logic [8:0] qm;
        if (!d) begin
            m_cnt = 0;
            case (c)
                2'b00:   s = 10'h354;
                2'b01:   s = 10'h0AB;
                2'b10:   s = 10'h154;
                default: s = 10'h2AB;
            endcase
        end else begin
            n1    = $countones(x);
            xn    = (n1 > 4) || (n1 == 4 && x[0] == 1'b0);
            qm    = '0;
            qm[0] = x[0];
            for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ x[i]) : (qm[i-1] ^ x[i]);
            qm[8] = !xn;
            n1q   = $countones(qm[7:0]);
            n0q   = 8 - n1q;
            if (m_cnt == 0 || n1q == n0q) begin
                s     = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                m_cnt = m_cnt + (qm[8] ? (n1q - n0q) : (n0q - n1q));
            end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
                s     = {1'b1, qm[8], ~qm[7:0]};
                m_cnt = m_cnt + 2 * int'(qm[8]) + (n0q - n1q);
            end else begin
                s     = {1'b0, qm[8], qm[7:0]};
                m_cnt = m_cnt + (n1q - n0q) - (qm[8] ? 0 : 2);
            end
        end
    endtask

    initial begin
        logic [9:0] e;
        rstn_i = 1'b0;
        de     = 1'b0;
        ctrl   = 2'b00;
        din    = 8'h00;

        // Reset held with random inputs: control symbol of RST_CTRL throughout.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_pix);
            check("reset_hold", tmds, 10'h354);
            de   = 1'($urandom);
            ctrl = 2'($urandom);
            din  = 8'($urandom);
        end
        @(negedge clk_pix);
        rstn_i = 1'b1;
        de     = 1'b0;
        ctrl   = 2'b00;
        din    = 8'h00;

        // din=00 after blanking: disparity swings -8,2,-6,4,-4,6,-2,8,0 then restarts.
        add(0, 2'b00, 8'h00, 10'h354);
        add(0, 2'b00, 8'h00, 10'h354);
        add(1, 2'b00, 8'h00, 10'h100);
        add(1, 2'b00, 8'h00, 10'h3FF);
        add(1, 2'b00, 8'h00, 10'h100);
        add(1, 2'b00, 8'h00, 10'h3FF);
        add(1, 2'b00, 8'h00, 10'h100);
        add(1, 2'b00, 8'h00, 10'h3FF);
        add(1, 2'b00, 8'h00, 10'h100);
        add(1, 2'b00, 8'h00, 10'h3FF);
        add(1, 2'b00, 8'h00, 10'h100);
        add(1, 2'b00, 8'h00, 10'h100);
        run_seq("balance");

        // din=FF uses XNOR: 200 (cnt -8), then 0FF (cnt -2), 0FF (cnt 4), 200 (cnt -4).
        add(0, 2'b00, 8'h00, 10'h354);
        add(0, 2'b00, 8'h00, 10'h354);
        add(1, 2'b00, 8'hFF, 10'h200);
        add(1, 2'b00, 8'hFF, 10'h0FF);
        add(1, 2'b00, 8'hFF, 10'h0FF);
        add(1, 2'b00, 8'hFF, 10'h200);
        run_seq("xnor");

        // Control codes on consecutive cycles; din is ignored during blanking.
        add(0, 2'b00, 8'hA5, 10'h354);
        add(0, 2'b01, 8'h3C, 10'h0AB);
        add(0, 2'b10, 8'hFF, 10'h154);
        add(0, 2'b11, 8'h00, 10'h2AB);
        // Four-ones words: 55 takes XOR (q_m 33), AA takes XNOR (q_m CC); both balanced.
        add(1, 2'b11, 8'h55, 10'h133);
        add(1, 2'b11, 8'hAA, 10'h233);
        run_seq("ctrl");

        // One blanking cycle clears cnt: second 00 symbol is 100, not 3FF.
        add(0, 2'b00, 8'h00, 10'h354);
        add(1, 2'b00, 8'h00, 10'h100);
        add(0, 2'b00, 8'h00, 10'h354);
        add(1, 2'b00, 8'h00, 10'h100);
        add(1, 2'b00, 8'h00, 10'h3FF);
        run_seq("cnt_clear");

        // Single-cycle data pulse lands exactly LAT cycles after it is driven.
        add(0, 2'b00, 8'h00, 10'h354);
        add(0, 2'b00, 8'h00, 10'h354);
        add(1, 2'b01, 8'h10, 10'h1F0);
        add(0, 2'b01, 8'h10, 10'h0AB);
        add(0, 2'b00, 8'h00, 10'h354);
        run_seq("pulse");

        // Mid-stream reset: build up negative disparity, then reset between edges.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_pix);
            de   = 1'b1;
            ctrl = 2'b00;
            din  = 8'h00;
        end
        @(posedge clk_pix);
        #2;
        rstn_i = 1'b0;
        #1;
        check("reset_async", tmds, 10'h354);
        @(negedge clk_pix);
        check("reset_mid_hold", tmds, 10'h354);
        rstn_i = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk_pix);
            e = (k < LAT - 1) ? 10'h354 : ((k == LAT - 1) ? 10'h100 : 10'h3FF);
            check($sformatf("reset_resume[%0d]", k), tmds, e);
        end

        // Random run against the model, starting from flushed blanking.
        for (int i = 0; i < LAT + 1; i++) begin
            @(negedge clk_pix);
            de   = 1'b0;
            ctrl = 2'b00;
            din  = 8'h00;
        end
        m_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < 20000 + LAT; i++) begin
            @(negedge clk_pix);
            if (i >= LAT) check($sformatf("random[%0d]", i - LAT), tmds, exp_q.pop_front());
            if (i < 20000) begin
                de   = ($urandom_range(0, 7) != 0);
                ctrl = 2'($urandom);
                din  = 8'($urandom);
                model_step(de, ctrl, din, e);
                exp_q.push_back(e);
            end else begin
                de   = 1'b0;
                ctrl = 2'b00;
                din  = 8'h00;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
